mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the L1 caches and the line-wide main RAM. It arbitrates I-cache line fills against D-cache line fills and writebacks. It emulates a fixed RAM access latency and drives the RAM's 26-bit line address, 128-bit data and write-enable ports. Each transaction moves exactly one 128-bit line; the RAM is purely combinational, so all timing is imposed here.

## Interface
- LATENCY, 5, cycles spent in BUSY per transaction; legal range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- ic_req  in  1  I-cache line-fill request; held high until ic_ready.
- ic_addr  in  26  I-cache line address.
- ic_ready  out  1  one-cycle pulse: ic_data valid.
- ic_data  out  128  fill line for I-cache.
- dc_req  in  1  D-cache request; held high until dc_ready.
- dc_we  in  1  1 = writeback of dc_wdata, 0 = line fill.
- dc_addr  in  26  D-cache line address.
- dc_wdata  in  128  line to write.
- dc_ready  out  1  one-cycle pulse: fill data valid, or write done.
- dc_rdata  out  128  fill line for D-cache.
- ram_rd_addr  out  26  RAM read line address.
- ram_rdata  in  128  RAM read data (combinational from ram_rd_addr).
- ram_wr_addr  out  26  RAM write line address.
- ram_wdata  out  128  RAM write data.
- ram_we  out  1  RAM write strobe.
- busy  out  1  high in BUSY and DONE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, any request pending: grant one requester, then go to BUSY. On grant, latch:
  - owner,
  - address into both ram_rd_addr and ram_wr_addr,
  - we (forced 0 for I-cache),
  - wdata into ram_wdata,
  - counter = LATENCY-1.
- Arbitration uses a last_grant bit. When both requests are high, the requester not granted last wins. last_grant resets to I-cache, so the D-cache wins the first tie. A lone request always wins.
- BUSY:
  - Counter decrements each cycle.
  - In the cycle counter == 0 (the final BUSY cycle):
    - if we: ram_we = 1 for exactly this cycle;
    - else: capture ram_rdata into the shared response register rdata.
  - Then go to DONE.
- DONE:
  - Assert the owner's ready for one cycle. Update last_grant to the owner.
  - Go to IDLE.
- ic_data and dc_rdata are both driven from rdata. Writes leave rdata unchanged.
- Latched address and data are fixed for the whole transaction. Changes on the request inputs after the grant are ignored.
- If the owner drops its req during BUSY, the transaction still completes and ready still pulses.
- A request arriving while BUSY/DONE waits; the requester holds req.
- Addresses pass through unmodified; word scaling is the RAM's job.

## Timing
- Reset (async, low) forces:
  - state = IDLE, last_grant = I-cache, counter = 0;
  - ic_ready = dc_ready = ram_we = busy = 0;
  - rdata = 0, ram_rd_addr = ram_wr_addr = 0, ram_wdata = 0.
- ram_we drops immediately on reset assertion. An in-flight transaction is discarded with no ready, and the requester must reissue it.
- req high in cycle 0 (IDLE):
  - BUSY occupies cycles 1..LATENCY;
  - ram_we or the rdata capture happens in cycle LATENCY;
  - ready is high in cycle LATENCY+1;
  - IDLE returns in cycle LATENCY+2.
- Peak throughput is one line per LATENCY+2 cycles.
- Registered requesters see ready at the edge that ends DONE. They must have req low, or a new request presented, in the following IDLE cycle. A req still high in that IDLE cycle is treated as a new request.
- ram_we is never high outside the final BUSY cycle of a write, and never high two consecutive cycles.
- LATENCY = 1: a single BUSY cycle, which is also the capture/write cycle.

## Test plan
- Single I-fill, LATENCY=5: RAM line 0x3 = 0x...0A08 pattern, ic_req with ic_addr=3 in cycle 0 -> ic_ready pulses in cycle 6 only, ic_data equals line 3, ram_we stays 0.
- D-writeback: dc_we=1, dc_addr=0x40, dc_wdata=0xDEADBEEF_... -> ram_we high only in cycle 5 with ram_wr_addr=0x40. A following fill of 0x40 returns the written line. dc_rdata is unchanged by the write.
- Tie after reset: ic_req and dc_req both asserted in cycle 0 -> dc_ready in cycle 6, ic_ready in cycle 13.
- Back-to-back ties: both requests held continuously -> grants strictly alternate D, I, D, I. No requester waits more than one transaction.
- Address stability: change ic_addr in cycle 2 of a fill -> returned data still matches the address latched in cycle 0.
- Reset mid-BUSY of a write: pull reset low in cycle 3 -> ram_we never asserts, no ready pulse, all outputs at reset values. The reissued request then completes normally.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Cache-side and RAM-side signal bundle of the memory controller.
// slave is the controller's view, master the caches/RAM view.
interface mem_ctrl_if;
  logic         ic_req;
  logic [25:0]  ic_addr;
  logic         ic_ready;
  logic [127:0] ic_data;
  logic         dc_req;
  logic         dc_we;
  logic [25:0]  dc_addr;
  logic [127:0] dc_wdata;
  logic         dc_ready;
  logic [127:0] dc_rdata;
  logic [25:0]  ram_rd_addr;
  logic [127:0] ram_rdata;
  logic [25:0]  ram_wr_addr;
  logic [127:0] ram_wdata;
  logic         ram_we;
  logic         busy;

  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  ram_rdata,
    output ic_ready, ic_data,
    output dc_ready, dc_rdata,
    output ram_rd_addr, ram_wr_addr,
    output ram_wdata, ram_we, busy
  );

  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output ram_rdata,
    input  ic_ready, ic_data,
    input  dc_ready, dc_rdata,
    input  ram_rd_addr, ram_wr_addr,
    input  ram_wdata, ram_we, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// Line-wide memory controller: I/D-cache arbitration with a fixed
// emulated RAM latency, one 128-bit line per transaction.
module mem_ctrl #(
  parameter int unsigned LATENCY = 5
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t       r_state;
  state_t       w_next;
  logic         r_own;
  logic         r_last;
  logic         r_we;
  logic [3:0]   r_cnt;
  logic [25:0]  r_addr;
  logic [127:0] r_wdata;
  logic [127:0] r_rdata;
  logic         w_grant;
  logic         w_gnt_d;
  logic         w_fin;

  // D wins a tie unless it was the last owner (r_last: 1 = D)
  assign w_gnt_d = bus.dc_req & (~bus.ic_req | ~r_last);
  assign w_grant = bus.ic_req | bus.dc_req;
  assign w_fin   = (r_state == S_BUSY) && (r_cnt == 4'd0);

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      r_state == S_IDLE: if (w_grant) w_next = S_BUSY;
      r_state == S_BUSY: if (w_fin) w_next = S_DONE;
      r_state == S_DONE: w_next = S_IDLE;
      default:           w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_own   <= 1'b0;
      r_last  <= 1'b0;
      r_we    <= 1'b0;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_grant) begin
        r_own <= w_gnt_d;
        r_we  <= w_gnt_d & bus.dc_we;
        r_cnt <= CNT_INIT;
        r_addr <= w_gnt_d ? bus.dc_addr
                          : bus.ic_addr;
        if (w_gnt_d) r_wdata <= bus.dc_wdata;
      end
      if (r_state == S_BUSY && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_fin && !r_we)
        r_rdata <= bus.ram_rdata;
      if (r_state == S_DONE)
        r_last <= r_own;
    end
  end

  assign bus.ram_we      = w_fin & r_we;
  assign bus.ram_rd_addr = r_addr;
  assign bus.ram_wr_addr = r_addr;
  assign bus.ram_wdata   = r_wdata;
  assign bus.ic_data     = r_rdata;
  assign bus.dc_rdata    = r_rdata;
  assign bus.ic_ready    = (r_state == S_DONE) & ~r_own;
  assign bus.dc_ready    = (r_state == S_DONE) & r_own;
  assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: timeline model of grants/latency, RAM model,
// directed scenarios with literal expectations.
module tb_mem_ctrl;
  localparam int L = 5;
  localparam logic [127:0] PAT3 =
    128'h00030A08_00030A08_00030A08_00030A08;
  localparam logic [127:0] PAT5 =
    128'h00050A08_00050A08_00050A08_00050A08;
  localparam logic [127:0] PAT8 =
    128'h00080A08_00080A08_00080A08_00080A08;
  localparam logic [127:0] W1 =
    128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] W2 =
    128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_ctrl_if bus();

  mem_ctrl #(.LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM: unwritten lines hold a pattern derived from the address
  logic [255:0] wr_ok = '0;
  logic [127:0] wr_line [256];

  assign bus.ram_rdata = wr_ok[bus.ram_rd_addr[7:0]]
    ? wr_line[bus.ram_rd_addr[7:0]]
    : {4{bus.ram_rd_addr[15:0], 16'h0A08}};

  always @(posedge clk) begin
    if (bus.ram_we) begin
      wr_ok[bus.ram_wr_addr[7:0]]   <= 1'b1;
      wr_line[bus.ram_wr_addr[7:0]] <= bus.ram_wdata;
    end
  end

  function automatic logic [127:0] line_of(input logic [25:0] a);
    if (wr_ok[a[7:0]]) return wr_line[a[7:0]];
    return {4{a[15:0], 16'h0A08}};
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rq_cyc[$];
  bit rq_who[$];
  int we_q[$];

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               n, a, e, cyc);
    end
  endtask

  // Timeline model: a grant in cycle g makes cycles g+1..g+L+1
  // busy, writes/captures in g+L, readies in g+L+1.
  bit           m_act;
  int           m_g;
  bit           m_own;
  bit           m_we;
  bit           m_last;
  logic [25:0]  m_addr;
  logic [127:0] m_wd;
  logic [127:0] m_rd;

  initial begin
    bit e_we;
    bit e_icr;
    bit e_dcr;
    m_act = 0; m_last = 0; m_rd = '0;
    m_g = 0; m_own = 0; m_we = 0;
    m_addr = '0; m_wd = '0;
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        m_act = 0; m_last = 0; m_rd = '0;
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_we", 128'(bus.ram_we), 128'd0);
        chk("rst_icr", 128'(bus.ic_ready), 128'd0);
        chk("rst_dcr", 128'(bus.dc_ready), 128'd0);
        chk("rst_rdata", bus.dc_rdata, 128'd0);
        chk("rst_rdaddr", 128'(bus.ram_rd_addr), 128'd0);
        chk("rst_wraddr", 128'(bus.ram_wr_addr), 128'd0);
        chk("rst_wdata", bus.ram_wdata, 128'd0);
      end else begin
        e_we  = m_act && m_we && (cyc == m_g + L);
        e_icr = m_act && !m_own && (cyc == m_g + L + 1);
        e_dcr = m_act && m_own && (cyc == m_g + L + 1);
        chk("busy", 128'(bus.busy), 128'(m_act));
        chk("ram_we", 128'(bus.ram_we), 128'(e_we));
        chk("ic_ready", 128'(bus.ic_ready), 128'(e_icr));
        chk("dc_ready", 128'(bus.dc_ready), 128'(e_dcr));
        chk("ic_data", bus.ic_data, m_rd);
        chk("dc_rdata", bus.dc_rdata, m_rd);
        if (m_act) begin
          chk("rd_addr", 128'(bus.ram_rd_addr), 128'(m_addr));
          chk("wr_addr", 128'(bus.ram_wr_addr), 128'(m_addr));
        end
        if (e_we) chk("wdata", bus.ram_wdata, m_wd);
        if (bus.ram_we) we_q.push_back(cyc);
        if (bus.ic_ready || bus.dc_ready) begin
          rq_cyc.push_back(cyc);
          rq_who.push_back(bus.dc_ready);
        end
        if (m_act) begin
          if (cyc == m_g + L && !m_we) m_rd = line_of(m_addr);
          if (cyc == m_g + L + 1) begin
            m_last = m_own;
            m_act  = 0;
          end
        end else if (bus.ic_req || bus.dc_req) begin
          m_own  = bus.dc_req && (!bus.ic_req || !m_last);
          m_we   = m_own && bus.dc_we;
          m_addr = m_own ? bus.dc_addr : bus.ic_addr;
          m_wd   = bus.dc_wdata;
          m_g    = cyc;
          m_act  = 1;
        end
      end
      cyc++;
    end
  end

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic wait_rdy(input bit d, input int t0,
                          output int lat);
    bit got;
    got = 0;
    lat = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      nxt();
      if ((d && bus.dc_ready) || (!d && bus.ic_ready)) begin
        got = 1;
        lat = cyc - t0;
      end
    end
    if (d) bus.dc_req = 0;
    else   bus.ic_req = 0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got none expected pulse");
    end
    nxt();
  endtask

  task automatic xfer(input bit d, input bit we,
                      input logic [25:0] a,
                      input logic [127:0] wd,
                      output int t0, output int lat);
    if (d) begin
      bus.dc_req = 1; bus.dc_we = we;
      bus.dc_addr = a; bus.dc_wdata = wd;
    end else begin
      bus.ic_req = 1; bus.ic_addr = a;
    end
    t0 = cyc;
    wait_rdy(d, t0, lat);
  endtask

  initial begin
    int t0;
    int lat;
    int nw;
    int nr;
    int tic;
    int tdc;
    int seen;
    bit exp_who [4];
    bus.ic_req = 0; bus.ic_addr = '0;
    bus.dc_req = 0; bus.dc_we = 0;
    bus.dc_addr = '0; bus.dc_wdata = '0;
    #3 reset = 0;
    repeat (3) nxt();
    reset = 1;
    nxt();

    xfer(0, 0, 26'h3, '0, t0, lat);
    chk("ifill_lat", 128'(lat), 128'd6);
    chk("ifill_data", bus.ic_data, PAT3);
    chk("ifill_no_we", 128'(we_q.size()), 128'd0);

    nw = we_q.size();
    xfer(1, 1, 26'h40, W1, t0, lat);
    chk("wb_lat", 128'(lat), 128'd6);
    chk("wb_we_cnt", 128'(we_q.size() - nw), 128'd1);
    chk("wb_we_cyc", 128'(we_q[$] - t0), 128'd5);
    chk("wb_rdata_kept", bus.dc_rdata, PAT3);

    xfer(1, 0, 26'h40, '0, t0, lat);
    chk("rb_data", bus.dc_rdata, W1);

    reset = 0;
    nxt();
    reset = 1;
    bus.ic_req = 1; bus.ic_addr = 26'h7;
    bus.dc_req = 1; bus.dc_we = 0;
    bus.dc_addr = 26'h8;
    t0 = cyc; tic = -1; tdc = -1;
    for (int i = 0; i < 30 && (tic < 0 || tdc < 0); i++) begin
      nxt();
      if (bus.dc_ready) begin
        tdc = cyc - t0; bus.dc_req = 0;
        chk("tie_dc_data", bus.dc_rdata, PAT8);
      end
      if (bus.ic_ready) begin
        tic = cyc - t0; bus.ic_req = 0;
      end
    end
    chk("tie_dc_cyc", 128'(tdc), 128'd6);
    chk("tie_ic_cyc", 128'(tic), 128'd13);
    nxt();

    exp_who = '{1'b1, 1'b0, 1'b1, 1'b0};
    nr = rq_cyc.size();
    bus.ic_req = 1; bus.dc_req = 1;
    seen = 0;
    for (int i = 0; i < 60 && seen < 4; i++) begin
      nxt();
      if (bus.ic_ready || bus.dc_ready) seen++;
    end
    bus.ic_req = 0; bus.dc_req = 0;
    nxt();
    chk("b2b_cnt", 128'(rq_cyc.size() - nr), 128'd4);
    if (rq_cyc.size() - nr == 4) begin
      for (int k = 0; k < 4; k++)
        chk("b2b_who", 128'(rq_who[nr + k]), 128'(exp_who[k]));
      for (int k = 1; k < 4; k++)
        chk("b2b_gap",
            128'(rq_cyc[nr + k] - rq_cyc[nr + k - 1]),
            128'd7);
    end

    bus.ic_req = 1; bus.ic_addr = 26'h5;
    t0 = cyc;
    nxt(); nxt();
    bus.ic_addr = 26'h9;
    wait_rdy(0, t0, lat);
    chk("stable_lat", 128'(lat), 128'd6);
    chk("stable_data", bus.ic_data, PAT5);

    nw = we_q.size();
    nr = rq_cyc.size();
    bus.dc_req = 1; bus.dc_we = 1;
    bus.dc_addr = 26'h41; bus.dc_wdata = W2;
    repeat (3) nxt();
    reset = 0;
    repeat (2) nxt();
    chk("abort_no_we", 128'(we_q.size() - nw), 128'd0);
    chk("abort_no_rdy", 128'(rq_cyc.size() - nr), 128'd0);
    reset = 1;
    t0 = cyc;
    wait_rdy(1, t0, lat);
    chk("reissue_lat", 128'(lat), 128'd6);
    chk("reissue_we", 128'(we_q.size() - nw), 128'd1);
    chk("reissue_rdy", 128'(rq_cyc.size() - nr), 128'd1);
    bus.dc_we = 0;
    xfer(1, 0, 26'h41, '0, t0, lat);
    chk("reissue_rb", bus.dc_rdata, W2);

    repeat (3) nxt();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
